spi_slave_param: RTL and testbench
==================================

// Module: spi_slave_param
// PURPOSE
//  Parametrised SPI slave front-end for the SPI-wrapper/RAM subsystem; successor to the fixed 10-bit slave.
//  Frame: 1 select bit, then RX_W = DATA_W+2 bits ({cmd[1:0], payload}), MSB first, on MOSI.
//  Received words go to the RAM on rx_data/rx_valid; read data returns on tx_data/tx_valid and is serialised on MISO.
//  New over the fixed slave: width generics, read-address tracking on frame completion, tx-wait timeout, frame_err.
// PARAMETERS
//  DATA_W      8   payload/tx word width (>=2); RX_W = DATA_W+2
//  TX_TIMEOUT  16  max clk edges in TX_WAIT without tx_valid before abort; 0 = wait forever
// PORTS
//  clk        in   1       serial bit clock; all sampling on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  SS_n       in   1       slave select, active low, sampled synchronously
//  MOSI       in   1       serial data in
//  MISO       out  1       serial data out, registered
//  rx_data    out  RX_W    last completed received word {cmd, payload}
//  rx_valid   out  1       1-cycle pulse: rx_data updated
//  tx_data    in   DATA_W  read data from RAM
//  tx_valid   in   1       tx_data valid; only accepted in TX_WAIT
//  frame_err  out  1       1-cycle pulse: frame aborted (early SS_n or tx timeout)
//  rd_pending out  1       1 = read address stored, next read frame is READ_DATA
// BEHAVIOUR
//  Reset (async): state IDLE; MISO=0, rx_data=0, rx_valid=0, frame_err=0, rd_pending=0; counters 0.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
//  IDLE: SS_n=0 -> CHK_CMD. CHK_CMD: sample MOSI; 0 -> WRITE; 1 -> rd_pending ? READ_DATA : READ_ADD.
//  WRITE/READ_ADD/READ_DATA: shift MOSI in, RX_W edges. On RX_W-th edge: rx_data <= full word, rx_valid=1 next cycle.
//   WRITE -> DONE. READ_ADD -> DONE, rd_pending<=1. READ_DATA -> TX_WAIT, rd_pending<=0.
//  rd_pending changes only on completed frames (not on state entry).
//  TX_WAIT: edge with tx_valid=1 -> latch tx_data, MISO<=tx_data[DATA_W-1], -> TX_SHIFT.
//   TX_TIMEOUT>0 and TX_TIMEOUT edges without tx_valid -> frame_err pulse, -> DONE.
//  TX_SHIFT: DATA_W-1 further edges drive remaining bits MSB->LSB; next edge MISO<=0, -> DONE.
//  DONE: hold, ignore MOSI/tx_valid; SS_n=1 -> IDLE with no error.
//  MISO=0 in every state except the DATA_W bit cycles of a transmit.
//  rx_data holds its value between frames; rx_valid never asserts for aborted frames.
//  SS_n=1 in CHK_CMD/WRITE/READ_ADD/READ_DATA/TX_WAIT/TX_SHIFT: -> IDLE, frame_err pulse, MISO<=0,
//   no rx_valid, rd_pending unchanged. SS_n=1 on the edge of the last bit: abort wins, bit not captured.
//  SS_n=1 in IDLE or DONE: no error.
//  tx_valid outside TX_WAIT ignored; tx_valid held high in TX_SHIFT does not restart transmit.
//  Bit counter width $clog2(RX_W+1); wraps to 0 at every state exit.
//  Latency: rx_valid high 1 cycle after last bit edge, i.e. RX_W+1 edges after the CHK_CMD edge.
// TESTING
//  Write: SS_n low, MOSI 0,00,0xA5 (11 bits) -> rx_valid 1 cycle, rx_data=0x0A5, rd_pending=0, frame_err=0.
//  Read pair: 1,10,0x3C then SS_n high; 1,11,0x00, tx_valid+tx_data=0x96 after 2 cycles
//   -> rd_pending 1 then 0, MISO=1,0,0,1,0,1,1,0, then 0.
//  Abort: SS_n high after 5 payload bits of READ_ADD -> frame_err pulse, no rx_valid, rd_pending stays 0.
//  Timeout: READ_DATA frame, tx_valid held low -> frame_err on the 16th TX_WAIT edge, MISO stays 0.
//  Reset mid-TX_SHIFT after 3 bits -> MISO=0, rd_pending=0, state IDLE; next write frame correct.
//  DATA_W=16: write 0,01,0xBEEF -> rx_data=0x1BEEF after 18 bits.

Source files
------------

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: deserialises {cmd, payload} frames for the RAM
// and serialises read data back on MISO, with read-address tracking and tx-wait timeout.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              rd_pending
);

  localparam int RX_W  = DATA_W + 2;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TO_W-1:0]   wait_cnt;
  logic [RX_W-2:0]   rx_shift;
  logic [DATA_W-2:0] tx_shift;

  logic in_frame;
  logic abort;
  logic rx_last;
  logic tx_accept;
  logic tx_timeout;
  logic tx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Control decodes shared by the next-state logic and the datapath registers.
  always_comb begin
    in_frame   = (state != IDLE) && (state != DONE);
    abort      = in_frame && SS_n;
    rx_last    = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA)) &&
                 (bit_cnt == CNT_W'(RX_W - 1));
    tx_accept  = (state == TX_WAIT) && tx_valid;
    tx_timeout = (TX_TIMEOUT > 0) && (state == TX_WAIT) && !tx_valid &&
                 (wait_cnt == TO_W'(TX_TIMEOUT - 1));
    tx_last    = (state == TX_SHIFT) && (bit_cnt == CNT_W'(DATA_W - 1));
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (!SS_n) next_state = CHK_CMD;
        CHK_CMD:   next_state = MOSI ? (rd_pending ? READ_DATA : READ_ADD) : WRITE;
        WRITE:     if (rx_last) next_state = DONE;
        READ_ADD:  if (rx_last) next_state = DONE;
        READ_DATA: if (rx_last) next_state = TX_WAIT;
        TX_WAIT: begin
          if (tx_accept)       next_state = TX_SHIFT;
          else if (tx_timeout) next_state = DONE;
        end
        TX_SHIFT:  if (tx_last) next_state = DONE;
        DONE:      if (SS_n) next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // An abort always wins, even on the edge carrying the last bit of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rd_pending <= 1'b0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (abort) begin
        frame_err <= 1'b1;
        MISO      <= 1'b0;
        bit_cnt   <= '0;
        wait_cnt  <= '0;
      end else begin
        case (state)
          WRITE, READ_ADD, READ_DATA: begin
            rx_shift <= {rx_shift[RX_W-3:0], MOSI};
            if (rx_last) begin
              rx_data  <= {rx_shift, MOSI};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              if (state == READ_ADD)  rd_pending <= 1'b1;
              if (state == READ_DATA) rd_pending <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          TX_WAIT: begin
            if (tx_accept) begin
              tx_shift <= tx_data[DATA_W-2:0];
              MISO     <= tx_data[DATA_W-1];
              wait_cnt <= '0;
            end else if (tx_timeout) begin
              frame_err <= 1'b1;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + TO_W'(1);
            end
          end
          TX_SHIFT: begin
            if (tx_last) begin
              MISO    <= 1'b0;
              bit_cnt <= '0;
            end else begin
              MISO     <= tx_shift[DATA_W-2];
              tx_shift <= tx_shift << 1;
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
          end
          default: begin
            MISO     <= 1'b0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: an 8-bit instance for the frame tests
// and a 16-bit instance for the wide write; received words are checked via a scoreboard.
module tb_spi_slave_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n, mosi, tx_valid;
  logic [7:0]  tx_data;
  logic        miso, rx_valid, frame_err, rd_pending;
  logic [9:0]  rx_data;
  logic        ss16, mosi16, tx_valid16;
  logic [15:0] tx_data16;
  logic        miso16, rx_valid16, frame_err16, rd_pending16;
  logic [17:0] rx_data16;

  int checks   = 0;
  int fails    = 0;
  int rx_seen  = 0;
  int err_seen = 0;
  int rx_before, err_before;
  logic [17:0] exp_q[$];
  logic [17:0] exp16_q[$];
  bit          use16 = 1'b0;
  logic [7:0]  tx_byte;
  logic        miso_or;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_err(frame_err), .rd_pending(rd_pending)
  );

  spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16), .tx_valid(tx_valid16),
    .frame_err(frame_err16), .rd_pending(rd_pending16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rx_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_seen++;
      if (exp_q.size() == 0) checkOutput("rx_unexpected", 32'(rx_valid), 32'd0);
      else checkOutput("rx_data_sb", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (frame_err === 1'b1) err_seen++;
    if (rx_valid16 === 1'b1) begin
      if (exp16_q.size() == 0) checkOutput("rx16_unexpected", 32'(rx_valid16), 32'd0);
      else checkOutput("rx16_data_sb", 32'(rx_data16), 32'(exp16_q.pop_front()));
    end
  end

  task automatic applyStimulus(input logic ss, input logic m, input logic tv, input logic [7:0] td);
    @(negedge clk);
    if (use16) begin
      ss16   = ss;
      mosi16 = m;
    end else begin
      ss_n     = ss;
      mosi     = m;
      tx_valid = tv;
      tx_data  = td;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic sel, input logic [17:0] word, input int n);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, sel, 1'b0, 8'h00);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, word[i], 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    ss16 = 1'b1; mosi16 = 1'b0; tx_valid16 = 1'b0; tx_data16 = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_miso", 32'(miso), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_rd_pending", 32'(rd_pending), 32'd0);
    checkOutput("rst16_rx_data", 32'(rx_data16), 32'd0);
    checkOutput("rst16_miso", 32'(miso16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Plain write frame
    exp_q.push_back(18'h0A5);
    sendFrame(1'b0, 18'h0A5, 10);
    checkOutput("wr_rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("wr_rx_data", 32'(rx_data), 32'h0A5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("wr_rx_valid_clear", 32'(rx_valid), 32'd0);
    checkOutput("wr_rd_pending", 32'(rd_pending), 32'd0);
    checkOutput("wr_frame_err", 32'(frame_err), 32'd0);

    // Read pair: address then data with delayed tx_valid
    exp_q.push_back(18'h23C);
    sendFrame(1'b1, 18'h23C, 10);
    checkOutput("rdadd_pending_set", 32'(rd_pending), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(18'h300);
    sendFrame(1'b1, 18'h300, 10);
    checkOutput("rddata_pending_clr", 32'(rd_pending), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h96);
    checkOutput("txwait_miso", 32'(miso), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h96);
    tx_byte = 8'h96;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 1'b1, (i == 7) ? 8'h96 : 8'h00);
      checkOutput($sformatf("tx_miso_bit%0d", i), 32'(miso), 32'(tx_byte[i]));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    checkOutput("tx_end_miso", 32'(miso), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    checkOutput("done_ignores_tx", 32'(miso), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("read_no_err", 32'(frame_err), 32'd0);

    // Early SS_n during READ_ADD payload
    rx_before = rx_seen; err_before = err_seen;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, i[0], 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("abort_err", 32'(frame_err), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("abort_err_pulse", 32'(frame_err), 32'd0);
    checkOutput("abort_rd_pending", 32'(rd_pending), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("abort_no_rx", 32'(rx_seen), 32'(rx_before));
    checkOutput("abort_err_count", 32'(err_seen), 32'(err_before + 1));

    // SS_n rising on the last bit edge: abort wins
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("lastbit_err", 32'(frame_err), 32'd1);
    checkOutput("lastbit_no_rx", 32'(rx_valid), 32'd0);
    checkOutput("lastbit_rx_hold", 32'(rx_data), 32'h300);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // tx_valid never arrives: timeout after 16 TX_WAIT edges
    exp_q.push_back(18'h2AA);
    sendFrame(1'b1, 18'h2AA, 10);
    checkOutput("to_pending_set", 32'(rd_pending), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(18'h355);
    sendFrame(1'b1, 18'h355, 10);
    miso_or = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
      miso_or = miso_or | miso;
      if (i == 15) checkOutput("to_err_early", 32'(frame_err), 32'd0);
      if (i == 16) checkOutput("to_err", 32'(frame_err), 32'd1);
    end
    checkOutput("to_miso", 32'(miso_or), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    checkOutput("to_done_ignore", 32'(miso), 32'd0);
    checkOutput("to_err_pulse", 32'(frame_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Reset during TX_SHIFT, then a fresh write
    exp_q.push_back(18'h211);
    sendFrame(1'b1, 18'h211, 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(18'h322);
    sendFrame(1'b1, 18'h322, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hE0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pre_reset_miso", 32'(miso), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_miso", 32'(miso), 32'd0);
    checkOutput("mid_reset_pending", 32'(rd_pending), 32'd0);
    checkOutput("mid_reset_rx_data", 32'(rx_data), 32'd0);
    ss_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(18'h15A);
    sendFrame(1'b0, 18'h15A, 10);
    checkOutput("post_reset_wr", 32'(rx_data), 32'h15A);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // 16-bit payload instance
    use16 = 1'b1;
    exp16_q.push_back(18'h1BEEF);
    sendFrame(1'b0, 18'h1BEEF, 18);
    checkOutput("w16_rx_valid", 32'(rx_valid16), 32'd1);
    checkOutput("w16_rx_data", 32'(rx_data16), 32'h1BEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("w16_frame_err", 32'(frame_err16), 32'd0);
    checkOutput("w16_rd_pending", 32'(rd_pending16), 32'd0);
    use16 = 1'b0;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("sb16_drained", 32'(exp16_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
